fft_frame_serializer: RTL and testbench

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_frame_serializer.sv | 78 +++++++
 tb/tb_fft_frame_serializer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type and bit-reversal helper for the FFT frame serializer
package fft_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Reverse the low `width` bits of k; bits above `width` come back as zero.
  function automatic logic [31:0] bit_rev(input logic [31:0] k, input int width);
    logic [31:0] src;
    logic [31:0] r;
    src = k;
    r   = '0;
    for (int i = 0; i < width; i++) begin
      r   = {r[30:0], src[0]};
      src = {1'b0, src[31:1]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// rtl/fft_frame_serializer.sv - captures a parallel FFT frame and streams it point by point
module fft_frame_serializer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int N_LOG2      = 4,
  parameter int BIT_REVERSE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_valid_i,
  output logic                  frame_ready_o,
  input  logic [DATA_WIDTH-1:0] frame_i [(1<<N_LOG2)],
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [N_LOG2-1:0]     out_index_o,
  output logic                  out_last_o
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = '1;

  state_t                  state;
  logic [N_LOG2-1:0]       count;
  logic [N_LOG2-1:0]       count_nxt;
  logic [DATA_WIDTH-1:0]   buffer [N];
  logic                    accept;

  // Beat position to frame index: bit-reversed or natural order.
  function automatic logic [N_LOG2-1:0] map(input logic [N_LOG2-1:0] k);
    logic [31:0] w;
    w = 32'(k);
    if (BIT_REVERSE != 0) w = bit_rev(w, N_LOG2);
    return w[N_LOG2-1:0];
  endfunction

  assign count_nxt   = count + 1'b1;
  assign out_last_o  = out_valid_o && (count == LAST);
  assign out_index_o = map(count);

  // Ready in IDLE, or on the final beat so the next frame follows without a bubble.
  assign frame_ready_o = (state == IDLE) || (out_valid_o && out_ready_i && out_last_o);
  assign accept        = frame_valid_i && frame_ready_o;

  // Frame buffer only changes on acceptance; later reads see the captured copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) buffer[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) buffer[i] <= frame_i[i];
    end
  end

  // Control FSM with registered point output; first point bypasses the buffer for 1-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
    end else if (accept) begin
      state       <= STREAM;
      count       <= '0;
      out_valid_o <= 1'b1;
      out_data_o  <= frame_i[map('0)];
    end else if (state == STREAM && out_valid_o && out_ready_i) begin
      if (count == LAST) begin
        state       <= IDLE;
        out_valid_o <= 1'b0;
      end else begin
        count       <= count_nxt;
        out_data_o  <= buffer[map(count_nxt)];
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_serializer.sv
// tb/tb_fft_frame_serializer.sv - self-checking bench for both point orderings against a frame-level model
module tb_fft_frame_serializer;

  logic       clk;
  logic       rst_n;
  logic       frame_valid;
  logic       out_ready;
  logic [7:0] frame_in [16];

  logic       ready_br, valid_br, last_br;
  logic [7:0] data_br;
  logic [3:0] idx_br;
  logic       ready_nat, valid_nat, last_nat;
  logic [7:0] data_nat;
  logic [3:0] idx_nat;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: whether a frame is in flight, which beat is showing, and the accepted frame.
  int m_busy = 0;
  int m_k    = 0;
  int m_frame [16];

  fft_frame_serializer #(.DATA_WIDTH(8), .N_LOG2(4), .BIT_REVERSE(1)) dut_br (
    .clk(clk), .rst_n(rst_n), .frame_valid_i(frame_valid), .frame_ready_o(ready_br),
    .frame_i(frame_in), .out_valid_o(valid_br), .out_ready_i(out_ready),
    .out_data_o(data_br), .out_index_o(idx_br), .out_last_o(last_br)
  );

  fft_frame_serializer #(.DATA_WIDTH(8), .N_LOG2(4), .BIT_REVERSE(0)) dut_nat (
    .clk(clk), .rst_n(rst_n), .frame_valid_i(frame_valid), .frame_ready_o(ready_nat),
    .frame_i(frame_in), .out_valid_o(valid_nat), .out_ready_i(out_ready),
    .out_data_o(data_nat), .out_index_o(idx_nat), .out_last_o(last_nat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int rev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) if (((k >> b) & 1) != 0) r += 1 << (3 - b);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < 16; i++) frame_in[i] = 8'(base + i);
  endtask

  task automatic load_random;
    for (int i = 0; i < 16; i++) frame_in[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic post_check;
    int ib;
    chk("valid_br", 32'(valid_br), 32'(m_busy));
    chk("valid_nat", 32'(valid_nat), 32'(m_busy));
    if (m_busy != 0) begin
      ib = rev4(m_k);
      chk("data_br", 32'(data_br), 32'(m_frame[ib]));
      chk("index_br", 32'(idx_br), 32'(ib));
      chk("last_br", 32'(last_br), 32'(m_k == 15));
      chk("data_nat", 32'(data_nat), 32'(m_frame[m_k]));
      chk("index_nat", 32'(idx_nat), 32'(m_k));
      chk("last_nat", 32'(last_nat), 32'(m_k == 15));
    end else begin
      chk("last_idle_br", 32'(last_br), 32'd0);
      chk("last_idle_nat", 32'(last_nat), 32'd0);
    end
  endtask

  // One clock: drive inputs, check ready before the edge, advance the model, check outputs after.
  task automatic cycle(input logic fv, input logic ordy);
    int mr;
    frame_valid = fv;
    out_ready   = ordy;
    #1;
    mr = ((m_busy == 0) || (ordy && m_k == 15)) ? 1 : 0;
    chk("ready_br", 32'(ready_br), 32'(mr));
    chk("ready_nat", 32'(ready_nat), 32'(mr));
    @(posedge clk);
    if (fv && mr != 0) begin
      m_busy = 1;
      m_k    = 0;
      for (int i = 0; i < 16; i++) m_frame[i] = int'(frame_in[i]);
    end else if (m_busy != 0 && ordy) begin
      if (m_k == 15) m_busy = 0;
      else m_k++;
    end
    #1;
    post_check();
  endtask

  task automatic check_reset_outputs;
    chk("rst_valid_br", 32'(valid_br), 32'd0);
    chk("rst_last_br", 32'(last_br), 32'd0);
    chk("rst_data_br", 32'(data_br), 32'd0);
    chk("rst_index_br", 32'(idx_br), 32'd0);
    chk("rst_valid_nat", 32'(valid_nat), 32'd0);
    chk("rst_data_nat", 32'(data_nat), 32'd0);
    chk("rst_index_nat", 32'(idx_nat), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    out_ready   = 1'b0;
    load_frame(8'h10);
    #3;
    check_reset_outputs();
    // Frame offered during reset must not be captured.
    frame_valid = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    rst_n       = 1'b1;
    m_busy      = 0;

    // Single bit-reversed / natural frame with no backpressure.
    load_frame(8'h10);
    cycle(1'b1, 1'b1);
    chk("first_data_br", 32'(data_br), 32'h10);
    cycle(1'b0, 1'b1);
    chk("second_data_br", 32'(data_br), 32'h18);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1);
    chk("end_valid_br", 32'(valid_br), 32'd0);

    // Backpressure at beat 3 for five cycles.
    load_frame(8'h10);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0);
      chk("bp_data_br", 32'(data_br), 32'h1C);
      chk("bp_index_br", 32'(idx_br), 32'd12);
    end
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1);

    // Back-to-back frames through the last-beat path.
    load_frame(8'h10);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1);
    load_frame(8'h80);
    cycle(1'b1, 1'b1);
    chk("b2b_data_br", 32'(data_br), 32'h80);
    chk("b2b_data_nat", 32'(data_nat), 32'h80);
    chk("b2b_valid_br", 32'(valid_br), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);

    // Frame offered mid-stream at beat 7 is refused and does not disturb the stream.
    load_frame(8'h10);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
    load_random();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
    chk("mid_done_valid_br", 32'(valid_br), 32'd0);

    // Reset pulse at beat 9 aborts the frame immediately.
    load_frame(8'h10);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    m_busy = 0;
    m_k    = 0;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1);
    load_random();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);

    // Randomized frames, offers and backpressure.
    for (int c = 0; c < 400; c++) begin
      load_random();
      cycle(($urandom % 3) == 0, ($urandom % 4) != 0);
    end
    for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1);
    chk("drain_valid_br", 32'(valid_br), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
